calc_sequencer: RTL and testbench

- Top-level controller for the calculator datapath.
- Sequences entry of operand 1, operand 2 and the operator from the switches and confirm button, then launches the ALU with a start/done handshake.
- Captures the result or error and holds it for display until the user confirms again.
- Sits between the board I/O (switches, confirm button) and the ALU and seven-segment display blocks.

---
 rtl/calc_pkg.sv | 47 ++++
 rtl/calc_sequencer.sv | 133 +++++++++++++
 tb/tb_calc_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calculator: sequencer states, ALU opcodes and the
// display-prompt phase codes that collapse entry/release state pairs.
package calc_pkg;

    typedef enum logic [3:0] {
        ST_OP1     = 4'd0,
        ST_OP1_REL = 4'd1,
        ST_OP2     = 4'd2,
        ST_OP2_REL = 4'd3,
        ST_OPC     = 4'd4,
        ST_OPC_REL = 4'd5,
        ST_START   = 4'd6,
        ST_WAIT    = 4'd7,
        ST_SHOW    = 4'd8,
        ST_ERR     = 4'd9,
        ST_CLR_REL = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } opcode_t;

    localparam logic [2:0] PH_OP1  = 3'd0;
    localparam logic [2:0] PH_OP2  = 3'd1;
    localparam logic [2:0] PH_OPC  = 3'd2;
    localparam logic [2:0] PH_ALU  = 3'd3;
    localparam logic [2:0] PH_SHOW = 3'd4;
    localparam logic [2:0] PH_ERR  = 3'd5;
    localparam logic [2:0] PH_CLR  = 3'd6;

    function automatic logic [2:0] phase_of(input state_t s);
        case (s)
            ST_OP1, ST_OP1_REL: phase_of = PH_OP1;
            ST_OP2, ST_OP2_REL: phase_of = PH_OP2;
            ST_OPC, ST_OPC_REL: phase_of = PH_OPC;
            ST_START, ST_WAIT:  phase_of = PH_ALU;
            ST_SHOW:            phase_of = PH_SHOW;
            ST_ERR:             phase_of = PH_ERR;
            ST_CLR_REL:         phase_of = PH_CLR;
            default:            phase_of = PH_OP1;
        endcase
    endfunction

endpackage

// File: rtl/calc_sequencer.sv
// Calculator controller: collects operand1/operand2/opcode on confirm presses,
// launches the ALU, and holds result or error until the next press.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int RES_W       = 8,
    parameter int ALU_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              confirm,
    input  logic              alu_done,
    input  logic [RES_W-1:0]  alu_result,
    input  logic              alu_err,
    output logic [DATA_W-1:0] operand1,
    output logic [DATA_W-1:0] operand2,
    output logic [1:0]        opcode,
    output logic              alu_start,
    output logic [RES_W-1:0]  result,
    output logic              result_valid,
    output logic              error,
    output logic [2:0]        phase
);

    localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] operand1_q, operand1_d;
    logic [DATA_W-1:0] operand2_q, operand2_d;
    opcode_t           opcode_q, opcode_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              alu_start_q, alu_start_d;
    logic              result_valid_q, result_valid_d;
    logic              error_q, error_d;
    logic [2:0]        phase_q, phase_d;

    always_comb begin
        state_d    = state_q;
        operand1_d = operand1_q;
        operand2_d = operand2_q;
        opcode_d   = opcode_q;
        result_d   = result_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_OP1: if (confirm) begin
                operand1_d = sw;
                state_d    = ST_OP1_REL;
            end
            ST_OP1_REL: if (!confirm) state_d = ST_OP2;
            ST_OP2: if (confirm) begin
                operand2_d = sw;
                state_d    = ST_OP2_REL;
            end
            ST_OP2_REL: if (!confirm) state_d = ST_OPC;
            ST_OPC: if (confirm) begin
                opcode_d = opcode_t'(sw[1:0]);
                state_d  = ST_OPC_REL;
            end
            ST_OPC_REL: if (!confirm) state_d = ST_START;
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A completing ALU wins over a coincident timeout.
                if (alu_done) begin
                    result_d = alu_err ? '0 : alu_result;
                    state_d  = alu_err ? ST_ERR : ST_SHOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_SHOW, ST_ERR: if (confirm) state_d = ST_CLR_REL;
            ST_CLR_REL: if (!confirm) state_d = ST_OP1;
            default: state_d = ST_OP1;
        endcase

        // Every way back into OP1 starts a fresh calculation.
        if (state_d == ST_OP1 && state_q != ST_OP1) begin
            operand1_d = '0;
            operand2_d = '0;
            opcode_d   = OP_ADD;
            result_d   = '0;
        end

        alu_start_d    = (state_q == ST_START);
        result_valid_d = (state_d == ST_SHOW);
        error_d        = (state_d == ST_ERR);
        phase_d        = phase_of(state_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_OP1;
            operand1_q     <= '0;
            operand2_q     <= '0;
            opcode_q       <= OP_ADD;
            result_q       <= '0;
            cnt_q          <= '0;
            alu_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
            phase_q        <= PH_OP1;
        end else begin
            state_q        <= state_d;
            operand1_q     <= operand1_d;
            operand2_q     <= operand2_d;
            opcode_q       <= opcode_d;
            result_q       <= result_d;
            cnt_q          <= cnt_d;
            alu_start_q    <= alu_start_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
            phase_q        <= phase_d;
        end
    end

    assign operand1     = operand1_q;
    assign operand2     = operand2_q;
    assign opcode       = opcode_q;
    assign alu_start    = alu_start_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;
    assign phase        = phase_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: entry sequencing, ALU handshake,
// error/timeout paths, held confirm, stray alu_done and async reset.
module tb_calc_sequencer;

    localparam int DATA_W      = 4;
    localparam int RES_W       = 8;
    localparam int ALU_TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DATA_W-1:0] sw;
    logic              confirm;
    logic              alu_done;
    logic [RES_W-1:0]  alu_result;
    logic              alu_err;
    logic [DATA_W-1:0] operand1;
    logic [DATA_W-1:0] operand2;
    logic [1:0]        opcode;
    logic              alu_start;
    logic [RES_W-1:0]  result;
    logic              result_valid;
    logic              error;
    logic [2:0]        phase;

    int n_chk  = 0;
    int n_pass = 0;
    int start_cnt = 0;
    int base;

    calc_sequencer #(
        .DATA_W(DATA_W), .RES_W(RES_W), .ALU_TIMEOUT(ALU_TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sw(sw), .confirm(confirm),
        .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
        .operand1(operand1), .operand2(operand2), .opcode(opcode),
        .alu_start(alu_start), .result(result), .result_valid(result_valid),
        .error(error), .phase(phase)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (alu_start) start_cnt++;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [DATA_W-1:0] val);
        sw = val;
        confirm = 1'b1;
        step();
        confirm = 1'b0;
        step();
    endtask

    task automatic done_pulse(input logic [RES_W-1:0] res, input logic err);
        alu_done = 1'b1;
        alu_result = res;
        alu_err = err;
        step();
        alu_done = 1'b0;
        alu_result = '0;
        alu_err = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_phase"}, 32'(phase), 0);
        check({tag, "_op1"}, 32'(operand1), 0);
        check({tag, "_op2"}, 32'(operand2), 0);
        check({tag, "_opc"}, 32'(opcode), 0);
        check({tag, "_res"}, 32'(result), 0);
        check({tag, "_rv"}, 32'(result_valid), 0);
        check({tag, "_err"}, 32'(error), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        sw = '0;
        confirm = 1'b0;
        alu_done = 1'b0;
        alu_result = '0;
        alu_err = 1'b0;
        step();
        check_cleared("rst");
        check("rst_start", 32'(alu_start), 0);
        reset_n = 1'b1;
        step();

        // 3 + 5 with ALU answering a few cycles after the start pulse
        base = start_cnt;
        press(4'd3);
        check("add_p1", 32'(phase), 1);
        press(4'd5);
        check("add_p2", 32'(phase), 2);
        press(4'd0);
        check("add_start_lo", 32'(alu_start), 0);
        step();
        check("add_start_hi", 32'(alu_start), 1);
        check("add_p3", 32'(phase), 3);
        step();
        check("add_start_end", 32'(alu_start), 0);
        step();
        done_pulse(8'd8, 1'b0);
        check("add_op1", 32'(operand1), 3);
        check("add_op2", 32'(operand2), 5);
        check("add_opc", 32'(opcode), 0);
        check("add_res", 32'(result), 8);
        check("add_rv", 32'(result_valid), 1);
        check("add_phase", 32'(phase), 4);
        check("add_pulses", 32'(start_cnt - base), 1);
        sw = 4'd9;
        step();
        check("show_hold", 32'(result), 8);
        confirm = 1'b1;
        step();
        check("clr_phase", 32'(phase), 6);
        check("clr_rv", 32'(result_valid), 0);
        confirm = 1'b0;
        step();
        check_cleared("clr1");

        // 7 / 0 reported as an ALU error
        press(4'd7);
        press(4'd0);
        press(4'd3);
        step();
        step();
        done_pulse(8'hAB, 1'b1);
        check("div_err", 32'(error), 1);
        check("div_res", 32'(result), 0);
        check("div_phase", 32'(phase), 5);
        check("div_rv", 32'(result_valid), 0);
        check("div_opc", 32'(opcode), 3);
        press(4'd0);
        check_cleared("clr2");

        // No alu_done: error must appear exactly ALU_TIMEOUT cycles into WAIT
        press(4'd1);
        press(4'd2);
        press(4'd1);
        step();
        check("to_wait", 32'(phase), 3);
        for (int i = 0; i < ALU_TIMEOUT - 1; i++) step();
        check("to_early", 32'(error), 0);
        check("to_early_ph", 32'(phase), 3);
        step();
        check("to_err", 32'(error), 1);
        check("to_phase", 32'(phase), 5);
        press(4'd0);
        check("to_clr", 32'(phase), 0);

        // confirm held with sw toggling: only the first cycle captures
        sw = 4'd9;
        confirm = 1'b1;
        step();
        for (int i = 0; i < 49; i++) begin
            sw = 4'(i * 7 + 2);
            step();
        end
        check("hold_op1", 32'(operand1), 9);
        check("hold_phase", 32'(phase), 0);
        check("hold_op2", 32'(operand2), 0);
        confirm = 1'b0;
        step();
        check("hold_rel", 32'(phase), 1);

        // Stray alu_done in OP2 is ignored; the real one is captured
        done_pulse(8'h55, 1'b0);
        check("stray_res", 32'(result), 0);
        check("stray_phase", 32'(phase), 1);
        check("stray_rv", 32'(result_valid), 0);
        press(4'd4);
        press(4'd2);
        step();
        step();
        done_pulse(8'd36, 1'b0);
        check("mul_res", 32'(result), 36);
        check("mul_op2", 32'(operand2), 4);
        check("mul_opc", 32'(opcode), 2);
        check("mul_phase", 32'(phase), 4);
        press(4'd0);

        // Asynchronous reset in the middle of WAIT
        press(4'd1);
        press(4'd1);
        press(4'd0);
        step();
        check("mid_wait", 32'(phase), 3);
        reset_n = 1'b0;
        #1;
        check_cleared("arst");
        check("arst_start", 32'(alu_start), 0);
        step();
        reset_n = 1'b1;
        step();
        done_pulse(8'd77, 1'b0);
        check("post_rst_res", 32'(result), 0);
        check("post_rst_phase", 32'(phase), 0);
        check("post_rst_rv", 32'(result_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
